multicycle_cu: RTL and testbench
================================

Name: multicycle_cu

Overview:
Multi-cycle control FSM for the RV32I multi-cycle core. It sequences a shared datapath (one ALU, one unified instruction/data memory port) through fetch, decode, execute, memory and writeback. It decodes the same opcode set as the single-cycle control unit (LUI, AUIPC, JAL, I-ALU, R-ALU, LW, SW, BRANCH). It waits on a memory ready handshake and emits per-state datapath enables.

Parameters:
FETCH_INC, 4, constant selected by alu_src_b=01. Documentation only; the datapath supplies the value.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
opcode  in  7  instruction[6:0] from IR; valid from DECODE onward
mem_ready  in  1  memory ack; completes an access in the cycle it is high while mem_read or mem_write is asserted
branch_taken  in  1  ALU compare result for the current branch (funct3 resolved in datapath)
pc_write  out  1  load PC
pc_src  out  1  0 = ALU result, 1 = alu_out register
ir_write  out  1  load IR and old_pc (old_pc <= PC)
iord  out  1  memory address select: 0 = PC, 1 = alu_out
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write
wb_sel  out  2  00 = alu_out, 01 = mem data, 10 = PC (link)
alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1
alu_src_b  out  2  00 = rs2, 01 = const 4, 10 = imm
alu_op  out  2  00 = pass B, 01 = sub, 10 = add, 11 = decode funct
state  out  3  current state, for debug and verification
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  high while in TRAP

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, JUMP=5, TRAP=6. 7 is unreachable; it decodes to FETCH on the next edge.
- Output model: Moore from the registered state. Exception: pc_write, ir_write and instr_done may also depend on mem_ready or branch_taken. Every output not listed for a state is 0.
- Reset: async assertion forces state=FETCH and all outputs to the FETCH-idle values (mem_read=1 only after rst deasserts).
  - Reset mid-access abandons any outstanding memory transaction.
  - First fetch begins on the first clk edge after deassertion.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=10.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
  - Otherwise stay; hold with no side effects, unbounded.
- DECODE: alu_src_a=01, alu_src_b=10, alu_op=10 (alu_out <= branch/jump target).
  - Next state by opcode: 0110111, 0010111, 0010011, 0110011, 0000011, 0100011, 1100011 go to EXEC.
  - 1101111 goes to JUMP.
  - Any other opcode goes to TRAP.
- EXEC, per opcode:
  - LUI: b=10, op=00.
  - AUIPC: a=01, b=10, op=10.
  - I-ALU: a=10, b=10, op=11.
  - R-ALU: a=10, b=00, op=11.
  - LW/SW: a=10, b=10, op=10.
  - BRANCH: a=10, b=00, op=01, pc_src=1, pc_write=branch_taken, instr_done=1.
  - Next state: BRANCH goes to FETCH; LW/SW go to MEM; all others go to WB.
- MEM: iord=1.
  - LW: mem_read=1.
  - SW: mem_write=1.
  - Stay until mem_ready.
  - On ready: LW goes to WB; SW goes to FETCH with instr_done=1.
- WB: reg_write=1, wb_sel=01 for LW, else 00; instr_done=1; next state FETCH.
- JUMP: reg_write=1, wb_sel=10, pc_write=1, pc_src=1, instr_done=1; next state FETCH.
- TRAP: illegal=1, all enables 0, sticky until rst.
- mem_read and mem_write are never both high. reg_write and mem_write are never both high.
- Opcode is sampled combinationally each cycle from DECODE through MEM/WB; the IR is stable because ir_write only asserts in FETCH.
- Cycles per instruction with mem_ready tied high:
  - BRANCH: 3.
  - SW, ALU ops, LUI, AUIPC: 4.
  - JAL: 3.
  - LW: 5.
  - Each cycle mem_ready is low inside FETCH or MEM adds one cycle.

Test Plan:
- Reset: rst=1 mid-MEM of an LW -> state=0 immediately (before the next edge), reg_write=0, mem_read=0 during reset. After deassert: mem_read=1, iord=0.
- R-type 0110011, mem_ready=1 -> state sequence 0,1,2,4,0. EXEC shows alu_src_a=10, alu_src_b=00, alu_op=11. WB shows reg_write=1, wb_sel=00. instr_done high exactly once.
- LW 0000011 with mem_ready low for 3 cycles in FETCH and 2 in MEM -> 10 cycles total. MEM shows iord=1, mem_read=1. WB shows wb_sel=01.
- SW 0100011 -> sequence 0,1,2,3,0. mem_write=1 only in MEM. reg_write never asserted.
- BRANCH 1100011, branch_taken=1 then 0 on a second instance -> pc_write=1 with pc_src=1 in EXEC on the first, pc_write=0 on the second. Both instances return to FETCH after 3 cycles.
- JAL 1101111 -> sequence 0,1,5,0 with wb_sel=10, reg_write=1, pc_write=1. Then opcode 1111111 -> state 6, illegal=1 held for 20 cycles, cleared only by rst.

Source files
------------

// File: rtl/multicycle_cu.sv
// rtl/multicycle_cu.sv - RV32I multi-cycle control FSM sequencing fetch/decode/exec/mem/writeback
module multicycle_cu #(
    parameter int FETCH_INC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       pc_src,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       illegal
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_RALU  = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        JUMP   = 3'd5,
        TRAP   = 3'd6
    } state_t;

    state_t cur, nxt;
    logic   br_q, done_q, jump_pcw_q;
    logic   is_lw, is_sw, is_br, is_exec_op, fetch_ack;

    assign is_lw      = (opcode == OP_LW);
    assign is_sw      = (opcode == OP_SW);
    assign is_br      = (opcode == OP_BR);
    assign is_exec_op = (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_IALU) ||
                        (opcode == OP_RALU) || is_lw || is_sw || is_br;

    // An access only completes while a request is actually driven; this also keeps the
    // first post-reset cycle (mem_read still low) from acknowledging a fetch.
    assign fetch_ack  = (cur == FETCH) && mem_read && mem_ready;
    assign ir_write   = fetch_ack;
    assign pc_write   = fetch_ack || jump_pcw_q || (br_q && branch_taken);
    assign instr_done = done_q || br_q || (mem_write && mem_ready);
    assign state      = cur;

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = fetch_ack ? DECODE : FETCH;
            DECODE:  nxt = is_exec_op ? EXEC : ((opcode == OP_JAL) ? JUMP : TRAP);
            EXEC:    nxt = is_br ? FETCH : ((is_lw || is_sw) ? MEM : WB);
            MEM:     nxt = mem_ready ? (is_lw ? WB : FETCH) : MEM;
            WB:      nxt = FETCH;
            JUMP:    nxt = FETCH;
            TRAP:    nxt = TRAP;
            default: nxt = FETCH;
        endcase
    end

    // Moore outputs are registered against the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= FETCH;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            iord       <= 1'b0;
            reg_write  <= 1'b0;
            wb_sel     <= 2'b00;
            alu_src_a  <= 2'b00;
            alu_src_b  <= 2'b01;
            alu_op     <= 2'b10;
            pc_src     <= 1'b0;
            illegal    <= 1'b0;
            br_q       <= 1'b0;
            done_q     <= 1'b0;
            jump_pcw_q <= 1'b0;
        end else begin
            cur        <= nxt;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            iord       <= 1'b0;
            reg_write  <= 1'b0;
            wb_sel     <= 2'b00;
            alu_src_a  <= 2'b00;
            alu_src_b  <= 2'b00;
            alu_op     <= 2'b00;
            pc_src     <= 1'b0;
            illegal    <= 1'b0;
            br_q       <= 1'b0;
            done_q     <= 1'b0;
            jump_pcw_q <= 1'b0;
            case (nxt)
                FETCH: begin
                    mem_read  <= 1'b1;
                    alu_src_b <= 2'b01;
                    alu_op    <= 2'b10;
                end
                DECODE: begin
                    alu_src_a <= 2'b01;
                    alu_src_b <= 2'b10;
                    alu_op    <= 2'b10;
                end
                EXEC: begin
                    case (opcode)
                        OP_LUI: begin
                            alu_src_b <= 2'b10;
                        end
                        OP_AUIPC: begin
                            alu_src_a <= 2'b01;
                            alu_src_b <= 2'b10;
                            alu_op    <= 2'b10;
                        end
                        OP_IALU: begin
                            alu_src_a <= 2'b10;
                            alu_src_b <= 2'b10;
                            alu_op    <= 2'b11;
                        end
                        OP_RALU: begin
                            alu_src_a <= 2'b10;
                            alu_op    <= 2'b11;
                        end
                        OP_BR: begin
                            alu_src_a <= 2'b10;
                            alu_op    <= 2'b01;
                            pc_src    <= 1'b1;
                            br_q      <= 1'b1;
                        end
                        default: begin
                            alu_src_a <= 2'b10;
                            alu_src_b <= 2'b10;
                            alu_op    <= 2'b10;
                        end
                    endcase
                end
                MEM: begin
                    iord      <= 1'b1;
                    mem_read  <= is_lw;
                    mem_write <= is_sw;
                end
                WB: begin
                    reg_write <= 1'b1;
                    wb_sel    <= is_lw ? 2'b01 : 2'b00;
                    done_q    <= 1'b1;
                end
                JUMP: begin
                    reg_write  <= 1'b1;
                    wb_sel     <= 2'b10;
                    pc_src     <= 1'b1;
                    jump_pcw_q <= 1'b1;
                    done_q     <= 1'b1;
                end
                TRAP: begin
                    illegal <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_cu.sv
// tb/tb_multicycle_cu.sv - scoreboard bench for multicycle_cu
module tb_multicycle_cu;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_RALU = 7'b0110011, OP_LW = 7'b0000011, OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_BAD = 7'b1111111;

    logic clk = 1'b0, rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic mem_ready = 1'b0, branch_taken = 1'b0;
    logic pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write;
    logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_op;
    logic [2:0] state;
    logic instr_done, illegal;
    int checks = 0, errors = 0;

    typedef struct packed {
        logic [2:0] st;
        logic mr, mw, rw, io;
        logic [1:0] wb, a, b, op;
        logic pw, ps, irw, dn, ill;
    } obs_t;
    typedef struct {
        obs_t o;
        logic rdy;
    } item_t;
    item_t q[$];

    always #5 clk = ~clk;

    multicycle_cu dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
        .instr_done(instr_done), .illegal(illegal)
    );

    function automatic obs_t base(input logic [2:0] st, input logic [1:0] a, input logic [1:0] b,
                                  input logic [1:0] op);
        obs_t e = '0;
        e.st = st; e.a = a; e.b = b; e.op = op;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{st: state, mr: mem_read, mw: mem_write, rw: reg_write, io: iord, wb: wb_sel,
              a: alu_src_a, b: alu_src_b, op: alu_op, pw: pc_write, ps: pc_src,
              irw: ir_write, dn: instr_done, ill: illegal};
        return o;
    endfunction

    task automatic push(input obs_t o, input logic r);
        item_t it;
        it.o = o; it.rdy = r;
        q.push_back(it);
    endtask

    // Expected per-cycle trace straight from the state/opcode output tables.
    task automatic build(input logic [6:0] opc, input logic taken, input int fw, input int mw,
                         input int tc);
        obs_t e;
        for (int k = 0; k <= fw; k++) begin
            e = base(3'd0, 2'b00, 2'b01, 2'b10); e.mr = 1'b1;
            if (k == fw) begin e.irw = 1'b1; e.pw = 1'b1; end
            push(e, k == fw);
        end
        push(base(3'd1, 2'b01, 2'b10, 2'b10), 1'b1);
        case (opc)
            OP_JAL: begin
                e = base(3'd5, 2'b00, 2'b00, 2'b00);
                e.rw = 1'b1; e.wb = 2'b10; e.pw = 1'b1; e.ps = 1'b1; e.dn = 1'b1;
                push(e, 1'b1);
            end
            OP_BR: begin
                e = base(3'd2, 2'b10, 2'b00, 2'b01); e.ps = 1'b1; e.pw = taken; e.dn = 1'b1;
                push(e, 1'b1);
            end
            OP_LW, OP_SW: begin
                push(base(3'd2, 2'b10, 2'b10, 2'b10), 1'b1);
                for (int k = 0; k <= mw; k++) begin
                    e = base(3'd3, 2'b00, 2'b00, 2'b00); e.io = 1'b1;
                    if (opc == OP_LW) e.mr = 1'b1; else e.mw = 1'b1;
                    if (k == mw && opc == OP_SW) e.dn = 1'b1;
                    push(e, k == mw);
                end
                if (opc == OP_LW) begin
                    e = base(3'd4, 2'b00, 2'b00, 2'b00); e.rw = 1'b1; e.wb = 2'b01; e.dn = 1'b1;
                    push(e, 1'b1);
                end
            end
            OP_LUI, OP_AUIPC, OP_IALU, OP_RALU: begin
                if (opc == OP_LUI) push(base(3'd2, 2'b00, 2'b10, 2'b00), 1'b1);
                else if (opc == OP_AUIPC) push(base(3'd2, 2'b01, 2'b10, 2'b10), 1'b1);
                else if (opc == OP_IALU) push(base(3'd2, 2'b10, 2'b10, 2'b11), 1'b1);
                else push(base(3'd2, 2'b10, 2'b00, 2'b11), 1'b1);
                e = base(3'd4, 2'b00, 2'b00, 2'b00); e.rw = 1'b1; e.dn = 1'b1;
                push(e, 1'b1);
            end
            default: begin
                for (int k = 0; k < tc; k++) begin
                    e = base(3'd6, 2'b00, 2'b00, 2'b00); e.ill = 1'b1;
                    push(e, 1'($urandom));
                end
            end
        endcase
    endtask

    // Entered and left at posedge+1; exp_cyc is the cycle count from the CPI table.
    task automatic execute(input string name, input logic [6:0] opc, input logic taken,
                           input int fw, input int mw, input int tc, input int exp_cyc);
        item_t it;
        obs_t o;
        int cyc = 0, dn_cnt = 0, dn_at = 0;
        opcode = opc;
        build(opc, taken, fw, mw, tc);
        while (q.size() > 0) begin
            it = q.pop_front();
            mem_ready = it.rdy;
            branch_taken = (opc == OP_BR) ? taken : 1'($urandom);
            @(negedge clk);
            cyc++;
            o = sample();
            checks++;
            if (o.st !== it.o.st) begin
                errors++;
                $display("FAIL %s state cyc %0d: got %0d expected %0d", name, cyc, o.st, it.o.st);
            end
            checks++;
            if (o !== it.o) begin
                errors++;
                $display("FAIL %s outputs cyc %0d: got %h expected %h", name, cyc, o, it.o);
            end
            if (o.dn === 1'b1) begin dn_cnt++; dn_at = cyc; end
            @(posedge clk); #1;
        end
        if (exp_cyc > 0) begin
            checks++;
            if (dn_cnt !== 1 || dn_at !== exp_cyc) begin
                errors++;
                $display("FAIL %s instr_done: got %0d pulses last at cyc %0d expected 1 at %0d",
                         name, dn_cnt, dn_at, exp_cyc);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({state, mem_read, iord, reg_write, alu_src_b, alu_op} !== {3'd0, 3'b000, 2'b01, 2'b10}) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 00000001 10", {state, mem_read, iord, reg_write, alu_src_b, alu_op});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({mem_read, iord, state} !== {1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_first_fetch: got %b expected 10000", {mem_read, iord, state});
        end
        opcode = OP_LW; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({state, mem_read, iord} !== {3'd3, 2'b11}) begin
            errors++;
            $display("FAIL reset_reach_mem: got %b expected 01111", {state, mem_read, iord});
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({state, reg_write, mem_read, mem_write} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_async: got %b expected 000000", {state, reg_write, mem_read, mem_write});
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        rst = 1'b0;
        #1;
        checks++;
        if ({state, mem_read, ir_write, pc_write} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_hold: got %b expected 000000", {state, mem_read, ir_write, pc_write});
        end
        @(posedge clk); #1;
        checks++;
        if ({state, mem_read, iord} !== {3'd0, 2'b10}) begin
            errors++;
            $display("FAIL reset_release: got %b expected 00010", {state, mem_read, iord});
        end
    endtask

    task automatic test_rtype();
        execute("rtype", OP_RALU, 1'b0, 0, 0, 0, 4);
    endtask

    task automatic test_lw_stalls();
        execute("lw_stall", OP_LW, 1'b0, 3, 2, 0, 10);
    endtask

    task automatic test_sw();
        execute("sw", OP_SW, 1'b0, 0, 0, 0, 4);
    endtask

    task automatic test_branch();
        execute("br_taken", OP_BR, 1'b1, 0, 0, 0, 3);
        execute("br_not", OP_BR, 1'b0, 0, 0, 0, 3);
    endtask

    task automatic test_jal_trap();
        execute("jal", OP_JAL, 1'b0, 0, 0, 0, 3);
        execute("trap", OP_BAD, 1'b0, 0, 0, 20, 0);
        checks++;
        if ({state, illegal} !== {3'd6, 1'b1}) begin
            errors++;
            $display("FAIL trap_sticky: got %b expected 1101", {state, illegal});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({state, illegal} !== 4'b0000) begin
            errors++;
            $display("FAIL trap_clear: got %b expected 0000", {state, illegal});
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops[8];
        int fw, mw, base_cyc;
        ops = '{OP_LUI, OP_AUIPC, OP_IALU, OP_RALU, OP_LW, OP_SW, OP_BR, OP_JAL};
        for (int n = 0; n < 24; n++) begin
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            case (ops[n % 8])
                OP_LW: base_cyc = 5 + fw + mw;
                OP_SW: base_cyc = 4 + fw + mw;
                OP_BR, OP_JAL: base_cyc = 3 + fw;
                default: base_cyc = 4 + fw;
            endcase
            execute("b2b", ops[n % 8], 1'($urandom), fw, mw, 0, base_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stalls();
        test_sw();
        test_branch();
        test_jal_trap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
